// File: rtl/debouncer_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_n_if
//  Description : Bundles the raw input lines and the debounced outputs of
//                debouncer_n into a single CHANNELS-wide interface.
//                  io_in      raw asynchronous inputs, bit i = channel i
//                  io_level   debounced level per channel
//                  io_pulse   one-cycle press (and auto-repeat) pulse
//                  io_release one-cycle release pulse
//                  io_any     OR of io_level
//                master : side that drives io_in and consumes the results
//                slave  : the debouncer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface debouncer_n_if #(
    parameter int unsigned CHANNELS = 5
) ();
    logic [CHANNELS-1:0] io_in;
    logic [CHANNELS-1:0] io_level;
    logic [CHANNELS-1:0] io_pulse;
    logic [CHANNELS-1:0] io_release;
    logic                io_any;

    modport master (
        output io_in,
        input  io_level,
        input  io_pulse,
        input  io_release,
        input  io_any
    );

    modport slave (
        input  io_in,
        output io_level,
        output io_pulse,
        output io_release,
        output io_any
    );
endinterface
`default_nettype wire

// File: rtl/debouncer_n.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_n
//  Description : N-channel push-button / Pmod debouncer. Each channel has a
//                SYNC_STAGES-deep synchroniser and a stability counter; a
//                change of level is committed only after STABLE_CYCLES
//                consecutive synchronised samples that differ from the
//                current level. Commits produce registered one-cycle press
//                or release pulses.
//  Ports       : clock  - system clock
//                reset  - asynchronous, active-high reset
//                io     - debouncer_n_if.slave (io_in, io_level, io_pulse,
//                         io_release, io_any)
//  Options     : DEBOUNCE_REPEAT_EN - when defined, a held press produces
//                extra io_pulse strobes REPEAT_DELAY cycles after the press
//                pulse and every REPEAT_PERIOD cycles thereafter.
//  Revision    : 1.0 - initial release
// ============================================================================
module debouncer_n #(
    parameter int unsigned CHANNELS      = 5,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  wire logic    clock,
    input  wire logic    reset,
    debouncer_n_if.slave io
);

    localparam int unsigned c_cnt_w = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned c_rep_max =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned c_rep_w = $clog2(c_rep_max + 1);
    localparam logic [c_rep_w-1:0] c_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_period_last = c_rep_w'(REPEAT_PERIOD - 1);
`else
    // Repeat parameters have no effect in this build.
    logic w_unused_repeat;
    assign w_unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    logic [CHANNELS-1:0] w_level;
    logic [CHANNELS-1:0] w_pulse;
    logic [CHANNELS-1:0] w_release;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_cnt_w-1:0]     r_cnt;
        logic                   r_level;
        logic                   r_press;
        logic                   r_rel;
        logic                   w_s;
        logic                   w_commit;

        assign w_s      = r_sync[SYNC_STAGES-1];
        assign w_commit = (w_s != r_level) && (r_cnt == c_stable_last);

        // Bit 0 captures the raw pin; the MSB is the synchronised sample.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], io.io_in[ch]};
            end
        end

        // Any sample agreeing with the current level restarts the count,
        // which is what rejects bounces shorter than the window.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                if (w_s == r_level) begin
                    r_cnt <= '0;
                end else if (!w_commit) begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end else begin
                    r_level <= w_s;
                    r_cnt   <= '0;
                    r_press <= w_s;
                    r_rel   <= !w_s;
                end
            end
        end

`ifdef DEBOUNCE_REPEAT_EN
        logic [c_rep_w-1:0] r_rep_cnt;
        logic               r_rep_first;
        logic               r_rep_pulse;
        logic [c_rep_w-1:0] w_rep_last;

        // First interval after a press uses the delay, later ones the period.
        assign w_rep_last = r_rep_first ? c_delay_last : c_period_last;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b1;
                r_rep_pulse <= 1'b0;
            end else begin
                r_rep_pulse <= 1'b0;
                // Released (or releasing this cycle) channels hold the
                // counter at zero; a press commit also lands here since the
                // old level is still 0, so the count restarts at the press.
                if (!r_level || w_commit) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b1;
                end else if (r_rep_cnt == w_rep_last) begin
                    r_rep_cnt   <= '0;
                    r_rep_first <= 1'b0;
                    r_rep_pulse <= 1'b1;
                end else begin
                    r_rep_cnt <= r_rep_cnt + c_rep_w'(1);
                end
            end
        end

        assign w_pulse[ch] = r_press | r_rep_pulse;
`else
        assign w_pulse[ch] = r_press;
`endif

        assign w_level[ch]   = r_level;
        assign w_release[ch] = r_rel;
    end

    assign io.io_level   = w_level;
    assign io.io_pulse   = w_pulse;
    assign io.io_release = w_release;
    assign io.io_any     = |w_level;

endmodule
`default_nettype wire

// File: tb/tb_debouncer_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debouncer_n
//  Description : Scoreboard bench for debouncer_n (5 channels, 2 sync
//                stages, 4-sample window, repeat 10/3). A driver issues
//                directed and random input patterns and pushes the expected
//                outputs of every clock edge into a queue; a monitor on the
//                falling edge pops and compares them against the DUT.
//                Honours DEBOUNCE_REPEAT_EN in its reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debouncer_n;

    localparam int CH = 5;
    localparam int SS = 2;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int c_hold_pulses = 10;
`else
    localparam int c_hold_pulses = 1;
`endif

    typedef logic [3*CH:0] rec_t;   // {level, pulse, release, any}

    logic clk = 1'b0;
    logic rst = 1'b1;

    debouncer_n_if #(.CHANNELS(CH)) bus ();

    debouncer_n #(
        .CHANNELS     (CH),
        .SYNC_STAGES  (SS),
        .STABLE_CYCLES(SC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clk),
        .reset(rst),
        .io   (bus)
    );

    always #5 clk = ~clk;

    rec_t  exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";
    int    pulse_cnt[CH];
    int    rel_cnt[CH];

    // ---------------- reference model ----------------
    // hist : raw pin values still travelling through the synchroniser
    // win  : synchronised samples seen since the last commit/reset
    bit hist[CH][$];
    bit win[CH][$];
    bit m_level[CH];
    int press_edge[CH];
    int edge_n = 0;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            hist[c].delete();
            for (int k = 0; k < SS; k++) hist[c].push_back(1'b0);
            win[c].delete();
            m_level[c]    = 1'b0;
            press_edge[c] = 0;
        end
    endfunction

    function automatic rec_t model_edge(input logic [CH-1:0] in);
        logic [CH-1:0] lv, pu, rl;
        bit s, all_diff;
        int d;
        lv = '0; pu = '0; rl = '0;
        for (int c = 0; c < CH; c++) begin
            s = hist[c].pop_front();
            hist[c].push_back(in[c]);
            win[c].push_back(s);
            if (win[c].size() > SC) void'(win[c].pop_front());
            // Commit when the last SC samples since the previous commit all
            // disagree with the present level.
            all_diff = (win[c].size() == SC);
            for (int k = 0; k < win[c].size(); k++)
                if (win[c][k] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[c] = !m_level[c];
                win[c].delete();
                if (m_level[c]) begin
                    pu[c] = 1'b1;
                    press_edge[c] = edge_n;
                end else begin
                    rl[c] = 1'b1;
                end
            end
`ifdef DEBOUNCE_REPEAT_EN
            else if (m_level[c]) begin
                d = edge_n - press_edge[c];
                if (d == RD || (d > RD && (d - RD) % RP == 0)) pu[c] = 1'b1;
            end
`endif
            lv[c] = m_level[c];
        end
        d = 0;
        edge_n++;
        return {lv, pu, rl, |lv};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        rec_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.io_level, bus.io_pulse, bus.io_release, bus.io_any};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: got level=%b pulse=%b release=%b any=%b, expected level=%b pulse=%b release=%b any=%b",
                         phase, $time, a[3*CH:2*CH+1], a[2*CH:CH+1], a[CH:1], a[0],
                         e[3*CH:2*CH+1], e[2*CH:CH+1], e[CH:1], e[0]);
            end
            for (int c = 0; c < CH; c++) begin
                pulse_cnt[c] += int'(bus.io_pulse[c]);
                rel_cnt[c]   += int'(bus.io_release[c]);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) exp_q.push_back('0);
            else     exp_q.push_back(model_edge(bus.io_in));
            #2;
        end
    endtask

    // Reset lands mid-cycle, so outputs must already be 0 at the next
    // falling edge: the pending expectation for this cycle is overwritten.
    task automatic pulse_reset(input int n);
        rst = 1'b1;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
        tick(n);
        rst = 1'b0;
    endtask

    task automatic clear_tally();
        for (int c = 0; c < CH; c++) begin
            pulse_cnt[c] = 0;
            rel_cnt[c]   = 0;
        end
    endtask

    // Channels in mask must show ep pulses / er releases, others none.
    task automatic check_tally(input string name, input logic [CH-1:0] mask,
                               input int ep, input int er);
        int xp, xr;
        for (int c = 0; c < CH; c++) begin
            xp = mask[c] ? ep : 0;
            xr = mask[c] ? er : 0;
            n_tests++;
            if (pulse_cnt[c] != xp || rel_cnt[c] != xr) begin
                n_fail++;
                $display("FAIL %s ch%0d: pulses=%0d releases=%0d, expected pulses=%0d releases=%0d",
                         name, c, pulse_cnt[c], rel_cnt[c], xp, xr);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [CH-1:0] pat;
        bus.io_in = '0;
        model_reset();
        #2;
        phase = "reset_state";
        tick(2);
        rst = 1'b0;

        phase = "all_high_reset";
        clear_tally();
        bus.io_in = 5'b11111;
        tick(8);
        pulse_reset(2);
        tick(10);
        bus.io_in = '0;
        tick(8);
        check_tally("all_high_reset", 5'b11111, 2, 1);

        phase = "ch2_clean";
        clear_tally();
        bus.io_in = 5'b00100;
        tick(8);
        bus.io_in = '0;
        tick(8);
        check_tally("ch2_clean", 5'b00100, 1, 1);

        phase = "ch0_bounce";
        clear_tally();
        bus.io_in = 5'b00001; tick(3);
        bus.io_in = 5'b00000; tick(1);
        bus.io_in = 5'b00001; tick(8);
        bus.io_in = 5'b00000; tick(8);
        check_tally("ch0_bounce", 5'b00001, 1, 1);

        phase = "ch1_ch4_simul";
        clear_tally();
        bus.io_in = 5'b10010; tick(8);
        bus.io_in = 5'b00000; tick(8);
        check_tally("ch1_ch4_simul", 5'b10010, 1, 1);

        phase = "ch3_reset_midcount";
        clear_tally();
        bus.io_in = 5'b01000;
        tick(4);
        pulse_reset(1);
        tick(8);
        bus.io_in = '0;
        tick(8);
        check_tally("ch3_reset_midcount", 5'b01000, 1, 1);

        phase = "ch0_hold";
        clear_tally();
        bus.io_in = 5'b00001; tick(35);
        bus.io_in = 5'b00000; tick(12);
        check_tally("ch0_hold", 5'b00001, c_hold_pulses, 1);

        phase = "random";
        pat = '0;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulse_reset($urandom_range(1, 2));
            end
            pat = pat ^ CH'($urandom & $urandom);
            bus.io_in = pat;
            tick($urandom_range(1, 7));
        end
        if ($urandom_range(0, 1) == 0) bus.io_in = '1;
        tick(40);

        phase = "drain";
        bus.io_in = '0;
        tick(8);
        #5;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
